branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch target buffer (BTB) with per-entry 2-bit saturating direction counters and saturating statistics counters. It sits beside the IF stage of the pipelined core. The IF stage looks up the current PC combinationally and redirects fetch on a predicted-taken hit. The ID stage reports resolved branches on an update port. The update port returns a mispredict flag that drives the IF/ID flush.

## Interface
- ADDR_WIDTH, 32: instruction address width in bits; PCs are word-aligned, so bits [1:0] are ignored.
- INDEX_BITS, 4: log2 of the entry count (ENTRIES = 2^INDEX_BITS); legal range 1..8.
- CNT_WIDTH, 16: width of each statistics counter.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous invalidate of all entries; statistics are kept.
- if_pc  input  ADDR_WIDTH  fetch PC to look up.
- pred_taken  output  1  hit and counter MSB set.
- pred_next_pc  output  ADDR_WIDTH  stored target if pred_taken, else if_pc+4 (mod 2^ADDR_WIDTH).
- upd_valid  input  1  a resolved branch is presented this cycle.
- upd_pc  input  ADDR_WIDTH  PC of the resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  ADDR_WIDTH  actual target; ignored when upd_taken=0.
- upd_mispredict  output  1  combinational; valid only while upd_valid=1, 0 otherwise.
- branch_cnt  output  CNT_WIDTH  count of accepted updates, saturating.
- mispred_cnt  output  CNT_WIDTH  count of mispredicted updates, saturating.

## Operation
- Field split:
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2].
- Each entry holds: valid, tag, target (ADDR_WIDTH), ctr (2 bits).
- Lookup (combinational):
  - hit = valid[idx] && tag[idx]==tag(if_pc).
  - pred_taken = hit && ctr[1].
- Update evaluation, using table contents before the edge:
  - uhit = valid && tag match for upd_pc.
  - pdir = uhit && ctr[1].
  - upd_mispredict = (pdir != upd_taken) || (upd_taken && pdir && stored target != upd_target).
- Update write, on the edge when upd_valid=1 and clear=0:
  - uhit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - uhit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - miss, taken: allocate by overwriting the indexed entry. valid=1, tag=new tag, target=upd_target, ctr=2'b10 (weakly taken).
  - miss, not taken: no table write.
- Statistics:
  - branch_cnt increments on every upd_valid.
  - mispred_cnt increments when upd_valid && upd_mispredict.
  - Both hold at all-ones once saturated, never wrap, and keep counting while clear=1.
- Replacement is direct-mapped only; aliasing PCs with the same index evict each other.

## Timing
- Lookup latency is 0 cycles (combinational from if_pc). An update becomes visible to lookup on the cycle after its edge.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no write-through bypass.
- clear and upd_valid in the same cycle: clear wins, all valid bits go to 0, no allocation. Statistics still count the update, with mispredict evaluated against pre-clear contents.
- Reset values, applied immediately on rst low, including mid-operation:
  - all valid=0, all ctr=2'b01.
  - branch_cnt=0, mispred_cnt=0.
  - Outputs settle to pred_taken=0 and pred_next_pc=if_pc+4.
  - Tag and target storage need not be reset.
- While rst=0, state holds at reset values regardless of clk. The first update is taken on the first rising edge after rst deasserts.
- if_pc=all-ones-minus-3 wraps: pred_next_pc=0 on a miss.

## Test plan
- Reset, then sweep if_pc over 0x0..0x3C -> pred_taken=0 and pred_next_pc=if_pc+4 for every value; both statistics counters read 0.
- Update pc=0x40, taken, target=0x100 -> upd_mispredict=1. Next cycle, lookup 0x40 gives pred_taken=1 and pred_next_pc=0x100. branch_cnt=1, mispred_cnt=1.
- Then two not-taken updates at 0x40:
  - First: upd_mispredict=1, ctr goes 10->01, and lookup reports pred_taken=0.
  - Second: upd_mispredict=0, ctr=00.
  - Then two taken updates: ctr goes 01->10 and pred_taken is 1 again.
- Aliasing (INDEX_BITS=4):
  - Allocate 0x40 -> 0x100, then a taken update at 0x80 (same index, different tag) -> 0x200.
  - Lookup 0x40 is now a miss; lookup 0x80 gives 0x200.
  - A taken hit at 0x80 with target 0x300 flags upd_mispredict=1 and rewrites the target.
- Pulse clear together with upd_valid on a new PC -> all lookups miss next cycle and branch_cnt still increments. Assert rst mid-stream -> counters read 0 in the same cycle, without waiting for a clock edge.
- CNT_WIDTH=4, 20 consecutive mispredicted updates -> branch_cnt and mispred_cnt both stop at 15.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and saturating
// branch/mispredict statistics; combinational lookup for IF, resolution port for ID.
module branch_predictor #(
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_next_pc,
   input  logic                  upd_valid,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [ADDR_WIDTH-1:0] upd_target,
   output logic                  upd_mispredict,
   output logic [CNT_WIDTH-1:0]  branch_cnt,
   output logic [CNT_WIDTH-1:0]  mispred_cnt
);

   localparam int ENTRIES   = 1 << INDEX_BITS;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS - 2;

   logic [ENTRIES-1:0]    valid;
   logic [TAG_WIDTH-1:0]  tag_mem    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
   logic [1:0]            ctr_mem    [ENTRIES];

   logic [INDEX_BITS-1:0] if_idx;
   logic [TAG_WIDTH-1:0]  if_tag;
   logic                  if_hit;
   logic [INDEX_BITS-1:0] u_idx;
   logic [TAG_WIDTH-1:0]  u_tag;
   logic                  u_hit;
   logic                  u_pdir;
   logic                  u_mis;
   logic [1:0]            u_ctr;
   logic [1:0]            u_ctr_inc;
   logic [1:0]            u_ctr_dec;

   // Byte-offset bits of word-aligned PCs carry no information.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   assign if_idx = if_pc[INDEX_BITS+1:2];
   assign if_tag = if_pc[ADDR_WIDTH-1:INDEX_BITS+2];
   assign u_idx  = upd_pc[INDEX_BITS+1:2];
   assign u_tag  = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

   always_comb begin
      if_hit       = valid[if_idx] && (tag_mem[if_idx] == if_tag);
      pred_taken   = if_hit && ctr_mem[if_idx][1];
      pred_next_pc = pred_taken ? target_mem[if_idx] : if_pc + ADDR_WIDTH'(4);
   end

   // Mispredict is judged against the table as it stood before this edge.
   always_comb begin
      u_hit          = valid[u_idx] && (tag_mem[u_idx] == u_tag);
      u_ctr          = ctr_mem[u_idx];
      u_pdir         = u_hit && u_ctr[1];
      u_mis          = (u_pdir != upd_taken) ||
                       (upd_taken && u_pdir && (target_mem[u_idx] != upd_target));
      upd_mispredict = upd_valid && u_mis;
      u_ctr_inc      = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'b01;
      u_ctr_dec      = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'b01;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= 2'b01;
      end else if (clear) begin
         valid <= '0;
      end else if (upd_valid) begin
         if (u_hit) begin
            ctr_mem[u_idx] <= upd_taken ? u_ctr_inc : u_ctr_dec;
         end else if (upd_taken) begin
            valid[u_idx]   <= 1'b1;
            ctr_mem[u_idx] <= 2'b10;
         end
      end
   end

   // Tag/target need no reset: they are only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (rst && !clear && upd_valid && upd_taken) begin
         target_mem[u_idx] <= upd_target;
         if (!u_hit) tag_mem[u_idx] <= u_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (upd_valid) begin
         if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         if (u_mis && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
